// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic unit with valid/ready handshake and multi-beat fold mode
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] fold_res;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  f_op = a & b;
      3'b001:  f_op = a | b;
      3'b010:  f_op = a ^ b;
      3'b011:  f_op = ~(a | b);
      3'b100:  f_op = ~(a ^ b);
      3'b101:  f_op = a & ~b;
      3'b110:  f_op = a;
      default: f_op = ~a;
    endcase
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Inside a burst the op latched on the first beat governs every beat.
  assign step_op  = (state_q == ACCUM) ? {1'b0, op_q} : in_op;
  assign beat_res = f_op(step_op, in_a, in_b);
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    case (op_q)
      2'b00:   fold_res = acc_q & beat_res;
      2'b01:   fold_res = acc_q | beat_res;
      default: fold_res = acc_q ^ beat_res;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_c_d     = out_c_q;
    out_count_d = out_count_q;
    if (accept) begin
      if (state_q == IDLE) begin
        if (in_acc && (in_op < 3'd3)) begin
          op_d  = in_op[1:0];
          acc_d = beat_res;
          cnt_d = CNT_W'(1);
          if (in_last) begin
            out_valid_d = 1'b1;
            out_c_d     = beat_res;
            out_count_d = CNT_W'(1);
          end else begin
            state_d = ACCUM;
          end
        end else begin
          out_valid_d = 1'b1;
          out_c_d     = beat_res;
          out_count_d = CNT_W'(1);
        end
      end else begin
        acc_d = fold_res;
        cnt_d = cnt_inc;
        if (in_last) begin
          out_valid_d = 1'b1;
          out_c_d     = fold_res;
          out_count_d = cnt_inc;
          state_d     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_count = out_count_q;
  assign out_zero  = (out_c_q == '0);
  assign out_ones  = (out_c_q == '1);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe against a behavioural model
module tb_logic_unit_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_acc, in_last;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_valid, out_ready, out_zero, out_ones;
  logic [31:0] out_c;
  logic [7:0]  out_count;

  logic        s_in_valid, s_in_ready, s_in_acc, s_in_last;
  logic [31:0] s_in_a, s_in_b;
  logic [2:0]  s_in_op;
  logic        s_out_valid, s_out_ready, s_out_zero, s_out_ones;
  logic [31:0] s_out_c;
  logic [1:0]  s_out_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        acc;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  cnt;
  } exp_t;

  beat_t beats[$];
  exp_t  exp_q[$];

  logic_unit_pipe #(.WIDTH(32), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_zero(out_zero), .out_ones(out_ones), .out_count(out_count)
  );

  logic_unit_pipe #(.WIDTH(32), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_op(s_in_op), .in_acc(s_in_acc), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_c(s_out_c),
    .out_zero(s_out_zero), .out_ones(s_out_ones), .out_count(s_out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] f_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a ^ b);
      3'd5:    return a & ~b;
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  // Expected result of a fold: reduce every beat's f(A,B) with the burst op.
  function automatic exp_t fold_ref(input logic [2:0] op, input beat_t bs[$], input int max_cnt);
    exp_t e;
    e.c = (op == 3'd0) ? 32'hFFFF_FFFF : 32'h0;
    foreach (bs[i]) begin
      case (op)
        3'd0:    e.c = e.c & f_ref(op, bs[i].a, bs[i].b);
        3'd1:    e.c = e.c | f_ref(op, bs[i].a, bs[i].b);
        default: e.c = e.c ^ f_ref(op, bs[i].a, bs[i].b);
      endcase
    end
    e.cnt = 8'((bs.size() > max_cnt) ? max_cnt : bs.size());
    return e;
  endfunction

  task automatic add_single(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic acc, input logic last);
    beat_t bt;
    exp_t  e;
    bt = '{a: a, b: b, op: op, acc: acc, last: last};
    beats.push_back(bt);
    e.c   = f_ref(op, a, b);
    e.cnt = 8'd1;
    exp_q.push_back(e);
  endtask

  task automatic add_burst(input logic [2:0] op, input beat_t bs[$]);
    foreach (bs[i]) beats.push_back(bs[i]);
    exp_q.push_back(fold_ref(op, bs, 255));
  endtask

  task automatic gen_random(input int n);
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(2) != 0) begin
        logic [2:0] op;
        logic       acc;
        op  = 3'($urandom_range(7));
        acc = 1'($urandom_range(1));
        add_single($urandom, $urandom, op, acc,
                   (acc && op < 3) ? 1'b1 : 1'($urandom_range(1)));
      end else begin
        beat_t      bs[$];
        logic [2:0] op;
        int         len;
        op  = 3'($urandom_range(2));
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
          beat_t bt;
          bt.a    = $urandom;
          bt.b    = $urandom;
          bt.op   = (i == 0) ? op : 3'($urandom_range(7));
          bt.acc  = (i == 0) ? 1'b1 : 1'($urandom_range(1));
          bt.last = (i == len - 1);
          bs.push_back(bt);
        end
        add_burst(op, bs);
      end
    end
  endtask

  // Drives the beat queue and scores every retired result; called at a negedge.
  task automatic run(input string name, input bit rnd, input bit cont, input int budget);
    int          idx;
    int          cycles;
    bit          started;
    bit          prev_stall;
    logic [31:0] held;
    exp_t        e;
    idx = 0; cycles = 0; started = 0; prev_stall = 0; held = '0;
    while ((idx < beats.size() || exp_q.size() > 0) && cycles < budget) begin
      in_valid = (idx < beats.size()) && (!rnd || $urandom_range(3) != 0);
      if (idx < beats.size()) begin
        in_a = beats[idx].a; in_b = beats[idx].b; in_op = beats[idx].op;
        in_acc = beats[idx].acc; in_last = beats[idx].last;
      end
      out_ready = !rnd || $urandom_range(2) != 0;
      #1;
      check({name, " in_ready"}, in_ready, !out_valid || out_ready);
      if (prev_stall) check({name, " stall_stable"}, out_c, held);
      if (cont && started && exp_q.size() > 0) check({name, " continuous"}, out_valid, 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, " extra_output"}, 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check({name, " out_c"}, out_c, e.c);
          check({name, " out_count"}, out_count, e.cnt);
          check({name, " out_zero"}, out_zero, e.c == 32'h0);
          check({name, " out_ones"}, out_ones, e.c == 32'hFFFF_FFFF);
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = out_c;
      if (in_valid && in_ready) begin
        idx++;
        started = 1;
      end
      @(negedge clk);
      cycles++;
    end
    if (cycles >= budget) check({name, " timeout"}, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    beats.delete();
    exp_q.delete();
  endtask

  initial begin
    beat_t       bs[$];
    beat_t       bt;
    logic [31:0] sat_or;
    logic [31:0] exp1;
    logic [31:0] exp2;

    reset = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0; in_last = 0; out_ready = 1;
    s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_op = 0; s_in_acc = 0; s_in_last = 0; s_out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_c", out_c, 32'h0);
    check("rst out_count", out_count, 8'h0);
    check("rst out_zero", out_zero, 1'b1);
    check("rst out_ones", out_ones, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle in_ready", in_ready, 1'b1);

    // Eight ops back to back with full throughput; expected values are literal.
    begin
      logic [31:0] lit[8];
      lit = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
              32'h00FF_1234, 32'hF000_0000, 32'hF0F0_1234, 32'h0F0F_EDCB};
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        bt = '{a: 32'hF0F0_1234, b: 32'h0FF0_FFFF, op: 3'(i), acc: 1'b0, last: 1'b0};
        beats.push_back(bt);
        e.c = lit[i]; e.cnt = 8'd1;
        exp_q.push_back(e);
      end
      run("ops8", 0, 1, 100);
    end

    // XOR fold of four beats.
    begin
      exp_t e;
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      pa = '{32'h1, 32'h4, 32'h10, 32'h40};
      pb = '{32'h2, 32'h8, 32'h20, 32'h80};
      for (int i = 0; i < 4; i++) begin
        bt = '{a: pa[i], b: pb[i], op: 3'd2, acc: 1'b1, last: (i == 3)};
        beats.push_back(bt);
      end
      e.c = 32'hFF; e.cnt = 8'd4;
      exp_q.push_back(e);
      run("xorfold", 0, 0, 100);
    end

    // AND fold where beat 2 carries a different op that must be ignored.
    begin
      exp_t e;
      bt = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, op: 3'd0, acc: 1'b1, last: 1'b0};
      beats.push_back(bt);
      bt = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, op: 3'd1, acc: 1'b1, last: 1'b1};
      beats.push_back(bt);
      e.c = 32'hFFFF_FFFF; e.cnt = 8'd2;
      exp_q.push_back(e);
      run("andfold", 0, 0, 100);
    end

    // Backpressure: hold a result for five cycles, then retire it while taking the next beat.
    exp1 = f_ref(3'd0, 32'h1234_5678, 32'h0F0F_0F0F);
    exp2 = f_ref(3'd1, 32'h1234_5678, 32'h0F0F_0F0F);
    in_valid = 1; in_a = 32'h1234_5678; in_b = 32'h0F0F_0F0F; in_op = 3'd0; in_acc = 0; in_last = 0;
    out_ready = 0;
    #1;
    check("bp first_accept", in_ready, 1'b1);
    @(negedge clk);
    in_op = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp out_valid", out_valid, 1'b1);
      check("bp in_ready", in_ready, 1'b0);
      check("bp out_c", out_c, exp1);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    check("bp release in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 0;
    #1;
    check("bp next out_valid", out_valid, 1'b1);
    check("bp next out_c", out_c, exp2);
    @(negedge clk);
    check("bp drained", out_valid, 1'b0);

    // Randomized traffic with random stalls on both sides.
    gen_random(60);
    run("random", 1, 0, 5000);

    // Counter saturation on the CNT_W=2 instance: six-beat OR fold.
    sat_or = 32'h0;
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1; s_in_a = $urandom & 32'h0101_0101; s_in_b = $urandom & 32'h0010_0010;
      s_in_op = 3'd1; s_in_acc = 1; s_in_last = (i == 5);
      sat_or = sat_or | s_in_a | s_in_b;
      #1;
      check("sat in_ready", s_in_ready, 1'b1);
      check("sat no_early_out", s_out_valid, 1'b0);
      @(negedge clk);
    end
    s_in_valid = 0;
    #1;
    check("sat out_valid", s_out_valid, 1'b1);
    check("sat out_count", s_out_count, 2'd3);
    check("sat out_c", s_out_c, sat_or);
    @(negedge clk);

    // Reset in the middle of a fold: outputs clear at once and the burst is lost.
    in_valid = 1; in_a = 32'hA0; in_b = 32'h05; in_op = 3'd1; in_acc = 0; in_last = 0;
    @(negedge clk);
    in_a = 32'h3; in_b = 32'h1; in_op = 3'd2; in_acc = 1; in_last = 0;
    @(negedge clk);
    in_a = 32'h7; in_b = 32'h2;
    #1;
    check("pre_rst out_c", out_c, 32'hA5);
    reset = 1'b1;
    #1;
    check("mid_rst out_valid", out_valid, 1'b0);
    check("mid_rst out_c", out_c, 32'h0);
    check("mid_rst out_count", out_count, 8'h0);
    check("mid_rst out_zero", out_zero, 1'b1);
    check("mid_rst out_ones", out_ones, 1'b0);
    in_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    add_single(32'h5, 32'h5, 3'd2, 1'b0, 1'b0);
    run("post_rst", 0, 0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
